avalon_pio_ctrl: RTL

//  Parametrised Avalon-MM general-purpose I/O port with per-bit direction, atomic set/clear and input sync.

---
 rtl/pio_pkg.sv | 24 ++
 rtl/pio_edge_detect.sv | 51 +++++
 rtl/avalon_pio_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pio_pkg.sv
// ============================================================================
// Module      : pio_pkg
// Description : Register map and edge-type constants for the Avalon PIO block.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package pio_pkg;

    localparam logic [2:0] PIO_DATA     = 3'd0;
    localparam logic [2:0] PIO_DIR      = 3'd1;
    localparam logic [2:0] PIO_IRQ_MASK = 3'd2;
    localparam logic [2:0] PIO_EDGE_CAP = 3'd3;
    localparam logic [2:0] PIO_OUTSET   = 3'd4;
    localparam logic [2:0] PIO_OUTCLR   = 3'd5;
    localparam logic [2:0] PIO_PULSE    = 3'd6;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

`default_nettype wire

// File: rtl/pio_edge_detect.sv
// ============================================================================
// Module      : pio_edge_detect
// Description : Pin synchroniser, one delay flop and edge decode per bit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pio_edge_detect
    import pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = EDGE_RISE,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_pin,
    output logic [WIDTH-1:0] o_in_sync,
    output logic [WIDTH-1:0] o_edge_pulse
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_dly;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_dly <= '0;
        end else begin
            r_sync[0] <= i_pin;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_dly <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_in_sync = r_sync[SYNC_STAGES-1];

    // Decode uses only flopped values, so downstream irq cannot glitch on pins.
    generate
        if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign o_edge_pulse = ~o_in_sync & r_dly;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign o_edge_pulse = o_in_sync ^ r_dly;
        end else begin : g_rise
            assign o_edge_pulse = o_in_sync & ~r_dly;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/avalon_pio_ctrl.sv
// ============================================================================
// Module      : avalon_pio_ctrl
// Description : Avalon-MM GPIO with direction, atomic set/clear, edge-capture
//               irq and optional self-timed output pulse (macro PIO_PULSE_EN).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module avalon_pio_ctrl
    import pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '1,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] PULSE_MASK  = WIDTH'(1),
    parameter int               PULSE_CW    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_in_sync;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_data_nxt;
    logic [31:0]      w_rdata;
    logic             w_pulse_expire;
    logic             w_unused;

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;

    assign w_wr     = chipselect & ~write_n;
    assign w_wd     = writedata[WIDTH-1:0];
    assign w_unused = ^{writedata, PULSE_MASK, PULSE_CW[0]};

    pio_edge_detect #(
        .WIDTH       (WIDTH),
        .EDGE_TYPE   (EDGE_TYPE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_pin        (in_port),
        .o_in_sync    (w_in_sync),
        .o_edge_pulse (w_edge)
    );

`ifdef PIO_PULSE_EN
    logic [PULSE_CW-1:0] r_cnt;
    logic [PULSE_CW-1:0] w_n;

    assign w_n            = writedata[PULSE_CW-1:0];
    assign w_pulse_expire = (r_cnt == PULSE_CW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (w_wr && address == PIO_PULSE)
            r_cnt <= w_n;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - PULSE_CW'(1);
    end
`else
    assign w_pulse_expire = 1'b0;
`endif

    // Expiry is applied first so a same-cycle bus write overrides it.
    always_comb begin
        w_data_nxt = r_data;
        if (w_pulse_expire) w_data_nxt = w_data_nxt & ~PULSE_MASK;
        if (w_wr) begin
            case (address)
                PIO_DATA:   w_data_nxt = w_wd;
                PIO_OUTSET: w_data_nxt = w_data_nxt | w_wd;
                PIO_OUTCLR: w_data_nxt = w_data_nxt & ~w_wd;
`ifdef PIO_PULSE_EN
                PIO_PULSE:  w_data_nxt = (w_n != '0) ? (w_data_nxt | PULSE_MASK)
                                                     : (w_data_nxt & ~PULSE_MASK);
`endif
                default:    ;
            endcase
        end
    end

    assign w_clr = (w_wr && address == PIO_EDGE_CAP) ? w_wd : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= RESET_VALUE;
            r_dir  <= DIR_RESET;
            r_mask <= '0;
            r_cap  <= '0;
        end else begin
            r_data <= w_data_nxt;
            if (w_wr && address == PIO_DIR)      r_dir  <= w_wd;
            if (w_wr && address == PIO_IRQ_MASK) r_mask <= w_wd;
            // A new edge outranks a same-cycle write-1-clear.
            r_cap <= (r_cap & ~w_clr) | (w_edge & ~r_dir);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            PIO_DATA:     w_rdata[WIDTH-1:0] = (r_dir & r_data) | (~r_dir & w_in_sync);
            PIO_DIR:      w_rdata[WIDTH-1:0] = r_dir;
            PIO_IRQ_MASK: w_rdata[WIDTH-1:0] = r_mask;
            PIO_EDGE_CAP: w_rdata[WIDTH-1:0] = r_cap;
`ifdef PIO_PULSE_EN
            PIO_PULSE:    w_rdata[PULSE_CW-1:0] = r_cnt;
`endif
            default:      ;
        endcase
    end

    assign readdata = w_rdata;
    assign out_port = r_data;
    assign oe       = r_dir;
    assign irq      = |(r_cap & r_mask);

endmodule

`default_nettype wire
